// File: rtl/avalon_pio_debounced.sv
// Generic Avalon-MM PIO: synchronised, debounced inputs with edge capture and IRQ, plus an output register.
// Define PIO_DEBOUNCE_EN to build the per-bit debounce counters; otherwise inputs pass straight from the synchroniser.
module avalon_pio_debounced #(
    parameter int unsigned      WIDTH           = 18,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter int unsigned      EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0] IN_RESET        = '0,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] rd_val;
    logic [31:0]      rd_word;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_data, wr_mask, wr_cap;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            meta_q <= IN_RESET;
            sync_q <= IN_RESET;
        end else begin
            meta_q <= pins_in;
            sync_q <= meta_q;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    // A bounce back to the debounced level drops the count to zero.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^avs_writedata;
`else
    always_comb begin
        deb_d = sync_q;
    end

    logic unused_bits;
    assign unused_bits = ^{avs_writedata, 32'(DEBOUNCE_CYCLES)};
`endif

    always_comb begin
        wr_data = avs_write && (avs_address == 2'd0);
        wr_mask = avs_write && (avs_address == 2'd1);
        wr_cap  = avs_write && (avs_address == 2'd2);

        out_d  = wr_data ? avs_writedata[WIDTH-1:0] : out_q;
        mask_d = wr_mask ? avs_writedata[WIDTH-1:0] : mask_q;
        clr    = wr_cap  ? avs_writedata[WIDTH-1:0] : '0;

        if (EDGE_MODE == 0) begin
            edge_hit = deb_d & ~deb_q;
        end else if (EDGE_MODE == 1) begin
            edge_hit = ~deb_d & deb_q;
        end else begin
            edge_hit = deb_d ^ deb_q;
        end

        // A new edge beats a same-cycle write-1-to-clear.
        cap_d = (cap_q & ~clr) | edge_hit;
        irq_d = |(cap_q & mask_q);

        unique case (avs_address)
            2'd0:    rd_val = deb_q;
            2'd1:    rd_val = mask_q;
            2'd2:    rd_val = cap_q;
            default: rd_val = out_q;
        endcase
        rd_word = '0;
        rd_word[WIDTH-1:0] = rd_val;
        readdata_d = avs_read ? rd_word : readdata_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            deb_q      <= IN_RESET;
            out_q      <= OUT_RESET;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            deb_q      <= deb_d;
            out_q      <= out_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;
    assign pins_out     = out_q;

endmodule
